// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package serial_subtractor_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t SHIFT = 2'd1;
   localparam state_t DONE  = 2'd2;

   // Bit count of the cycle counter; a 1-bit counter is the minimum.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell (d = a - b - bin). It is the inverse
// primitive of the full-adder cell.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic bout,
   output logic d
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor, diff = a - b over WIDTH cycles.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds the signed overflow output ovf.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             brw;
   logic [CNT_W-1:0] cnt;
   logic             d_bit;
   logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             a_msb;
   logic             b_msb;
`endif

   full_subtractor u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (brw),
      .bout (bout),
      .d    (d_bit)
   );

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   // Result bits enter the top of a_sh as minuend bits leave the bottom, so
   // a_sh doubles as the partial-result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  brw   <= 1'b0;
                  cnt   <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh <= {d_bit, a_sh[WIDTH-1:1]};
               b_sh <= b_sh >> 1;
               brw  <= bout;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == CNT_MAX) begin
                  diff   <= {d_bit, a_sh[WIDTH-1:1]};
                  borrow <= bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  ovf    <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, hand
// sequences for handshake corner cases, and randomized operations.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic         ovf;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
      ,
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] exp_diff;
      logic         exp_borrow;
      logic         exp_ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         pass_cnt++;
   endtask

   // Reference: plain unsigned/signed arithmetic on the operands.
   function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] r;
      r = {1'b0, x} - {1'b0, y};
      return {(x < y), r[W-1:0]};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
      int r;
      r = int'($signed(x)) - int'($signed(y));
      return (r < -128) || (r > 127);
   endfunction

   // Launch one operation from IDLE and check latency, busy span and results.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] e_diff, input logic e_brw, input logic e_ovf,
                         input string tag);
      int  lat;
      int  bcnt;
      bit  seen;
      start = 1'b1;
      a = ta;
      b = tb;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      lat = 1;
      bcnt = 0;
      seen = 0;
      while (!seen && lat <= 20) begin
         if (busy) bcnt++;
         if (done) seen = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'd9);
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'd8);
      check({tag, "_diff"}, 64'(diff), 64'(e_diff));
      check({tag, "_borrow"}, 64'(borrow), 64'(e_brw));
`ifdef SERIAL_SUB_OVERFLOW_EN
      check({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
`else
      if (e_ovf === 1'bx) $display("unused ovf expectation");
`endif
      @(negedge clk);
      check({tag, "_done_width"}, 64'(done), 64'd0);
   endtask

   vec_t vecs[8];

   initial begin
      logic [W:0]   r;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           dcnt;
      int           dtimes[$];

      vecs[0] = '{8'd200, 8'd55, 8'd145, 1'b0, 1'b0};
      vecs[1] = '{8'd5,   8'd10, 8'd251, 1'b1, 1'b0};
      vecs[2] = '{8'h3C,  8'h3C, 8'h00,  1'b0, 1'b0};
      vecs[3] = '{8'h00,  8'h00, 8'h00,  1'b0, 1'b0};
      vecs[4] = '{8'hFF,  8'h00, 8'hFF,  1'b0, 1'b0};
      vecs[5] = '{8'h00,  8'hFF, 8'h01,  1'b1, 1'b0};
      vecs[6] = '{8'h80,  8'h01, 8'h7F,  1'b0, 1'b1};
      vecs[7] = '{8'h10,  8'h20, 8'hF0,  1'b1, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_diff", 64'(diff), 64'd0);
      check("rst_borrow", 64'(borrow), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_diff, vecs[i].exp_borrow,
                vecs[i].exp_ovf, $sformatf("vec%0d", i));

      // Start with new operands during SHIFT must be ignored
      run_op(8'd200, 8'd55, 8'd145, 1'b0, 1'b0, "pre_ign");
      start = 1'b1; a = 8'd50; b = 8'd20;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      dcnt = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3 || i == 4) begin
            start = 1'b1; a = 8'd1; b = 8'd200;
         end else begin
            start = 1'b0;
         end
         if (i == 7) check("ign_diff_held", 64'(diff), 64'd145);
         if (done) dcnt++;
         @(negedge clk);
      end
      start = 1'b0;
      check("ign_done_count", 64'(dcnt), 64'd1);
      check("ign_diff", 64'(diff), 64'd30);
      check("ign_borrow", 64'(borrow), 64'd0);

      // Reset asserted in the 4th SHIFT cycle aborts the operation
      start = 1'b1; a = 8'd9; b = 8'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_diff", 64'(diff), 64'd0);
      check("abort_borrow", 64'(borrow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) dcnt++;
         @(negedge clk);
      end
      check("abort_no_done", 64'(dcnt), 64'd0);
      run_op(8'd1, 8'd2, 8'd255, 1'b1, 1'b0, "post_abort");

      // start held high: one accept every WIDTH+2 cycles
      start = 1'b1; a = 8'd100; b = 8'd1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) dtimes.push_back(i);
      end
      start = 1'b0;
      check("b2b_pulses", 64'(dtimes.size()), 64'd4);
      if (dtimes.size() == 4) begin
         check("b2b_first", 64'(dtimes[0]), 64'd9);
         for (int k = 1; k < 4; k++)
            check($sformatf("b2b_gap%0d", k), 64'(dtimes[k] - dtimes[k-1]), 64'd10);
      end
      check("b2b_diff", 64'(diff), 64'd99);
      repeat (12) @(negedge clk);

      // Randomized operations against the arithmetic reference
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom_range(0, 255));
         rb = (n % 6 == 0) ? ra : W'($urandom_range(0, 255));
         r = ref_sub(ra, rb);
         run_op(ra, rb, r[W-1:0], r[W], ref_ovf(ra, rb), $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
